// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory arbiter slice.
package dmem_pkg;

    localparam int DMEM_ADDR_W = 8;
    localparam int DMEM_DATA_W = 32;
    localparam int STARVE_W    = 4;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        CPU  = 2'd1,
        DMA  = 2'd2
    } owner_t;

    // Owner of the read issued this cycle; at most one of the inputs is set.
    function automatic owner_t read_owner(input logic cpu_rd, input logic dma_rd);
        if (cpu_rd) return CPU;
        if (dma_rd) return DMA;
        return NONE;
    endfunction

endpackage

// File: rtl/dmem_arb_starve.sv
// Saturating count of consecutive denied DMA cycles; force_dma hands the next
// contested cycle to the DMA once the count reaches MAX_WAIT.
module dmem_arb_starve
    import dmem_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic dma_req,
    input  logic dma_gnt,
    output logic force_dma
);

    localparam logic [STARVE_W-1:0] WAIT_MAX = STARVE_W'(MAX_WAIT);

    logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;

    always_comb begin
        starve_cnt_d = '0;
        if (dma_req && !dma_gnt)
            starve_cnt_d = (starve_cnt_q == WAIT_MAX) ? starve_cnt_q : starve_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) starve_cnt_q <= '0;
        else     starve_cnt_q <= starve_cnt_d;
    end

    assign force_dma = (starve_cnt_q == WAIT_MAX);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU MEM stage and the DMA port.
// DMEM_ARB_RR_EN selects round-robin priority instead of CPU priority + starvation guard.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W   = DMEM_ADDR_W,
    parameter int DATA_W   = DMEM_DATA_W,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic   cpu_wins;
    owner_t rd_owner_q, rd_owner_d;

`ifdef DMEM_ARB_RR_EN
    // last_gnt_q: 1 = DMA was granted last, so the CPU goes first after reset.
    logic last_gnt_q, last_gnt_d;

    assign cpu_wins = cpu_req & (~dma_req | last_gnt_q);

    always_comb begin
        last_gnt_d = last_gnt_q;
        if (cpu_req || dma_req) last_gnt_d = ~cpu_wins;
    end

    always_ff @(posedge clk) begin
        if (rst) last_gnt_q <= 1'b1;
        else     last_gnt_q <= last_gnt_d;
    end
`else
    logic force_dma;

    dmem_arb_starve #(.MAX_WAIT(MAX_WAIT)) u_starve (
        .clk       (clk),
        .rst       (rst),
        .dma_req   (dma_req),
        .dma_gnt   (dma_gnt),
        .force_dma (force_dma)
    );

    assign cpu_wins = cpu_req & (~dma_req | ~force_dma);
`endif

    assign cpu_gnt   = cpu_wins;
    assign dma_gnt   = dma_req & ~cpu_wins;
    assign cpu_stall = cpu_req & ~cpu_gnt;

    always_comb begin
        mem_we    = (cpu_gnt & cpu_we)  | (dma_gnt & dma_we);
        mem_re    = (cpu_gnt & ~cpu_we) | (dma_gnt & ~dma_we);
        mem_addr  = dma_gnt ? dma_addr  : cpu_addr;
        mem_wdata = dma_gnt ? dma_wdata : cpu_wdata;
        rd_owner_d = read_owner(cpu_gnt & ~cpu_we, dma_gnt & ~dma_we);
    end

    always_ff @(posedge clk) begin
        if (rst) rd_owner_q <= NONE;
        else     rd_owner_q <= rd_owner_d;
    end

    // Gating with rst drops a read response that lands in a reset cycle.
    assign cpu_rvalid = (rd_owner_q == CPU) & ~rst;
    assign dma_rvalid = (rd_owner_q == DMA) & ~rst;
    assign cpu_rdata  = mem_rdata;
    assign dma_rdata  = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: external memory model, read expectations
// queued at grant and compared when rvalid appears.
module tb_dmem_arbiter;

    localparam int AW = 8;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req, cpu_we, dma_req, dma_we;
    logic [AW-1:0] cpu_addr, dma_addr, mem_addr;
    logic [DW-1:0] cpu_wdata, dma_wdata, mem_wdata, mem_rdata;
    logic [DW-1:0] cpu_rdata, dma_rdata;
    logic          cpu_gnt, cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid;
    logic          mem_we, mem_re;
    logic          preload;

    logic [DW-1:0] mem_arr [256];
    logic [DW-1:0] ref_mem [256];
    logic [DW-1:0] cpu_q[$];
    logic [DW-1:0] dma_q[$];
    int nchecks = 0;
    int nfails  = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    function automatic logic [DW-1:0] pat(input int i);
        return 32'hA500_0000 | 32'(i);
    endfunction

    // Expected DMA win in the k-th cycle of a contested run starting from reset.
    function automatic logic exp_dma_win(input int k);
`ifdef DMEM_ARB_RR_EN
        return (k % 2) == 0;
`else
        return (k % 5) == 0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchecks++;
        if (got !== exp) begin
            nfails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Single-port synchronous memory: read data registered one cycle after mem_re.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem_arr[i] <= pat(i);
            mem_arr[5] <= 32'hDEADBEEF;
        end else begin
            if (mem_we) mem_arr[mem_addr] <= mem_wdata;
            if (mem_re) mem_rdata <= mem_arr[mem_addr];
        end
    end

    // Scoreboard: pop responses first, then queue reads granted this cycle.
    always @(negedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
            ref_mem[5] = 32'hDEADBEEF;
        end else if (rst) begin
            cpu_q.delete();
            dma_q.delete();
            chk("rvalid_in_rst", {cpu_rvalid, dma_rvalid}, 2'b00);
        end else begin
            if (cpu_rvalid) begin
                if (cpu_q.size() == 0) chk("cpu_spurious_rvalid", 1, 0);
                else chk("cpu_rdata_sb", cpu_rdata, cpu_q.pop_front());
            end
            if (dma_rvalid) begin
                if (dma_q.size() == 0) chk("dma_spurious_rvalid", 1, 0);
                else chk("dma_rdata_sb", dma_rdata, dma_q.pop_front());
            end
            if (cpu_gnt && !cpu_we) cpu_q.push_back(ref_mem[cpu_addr]);
            if (cpu_gnt && cpu_we)  ref_mem[cpu_addr] = cpu_wdata;
            if (dma_gnt && !dma_we) dma_q.push_back(ref_mem[dma_addr]);
            if (dma_gnt && dma_we)  ref_mem[dma_addr] = dma_wdata;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cpu(input logic r, input logic w, input int a, input logic [DW-1:0] d);
        cpu_req = r; cpu_we = w; cpu_addr = AW'(a); cpu_wdata = d;
    endtask

    task automatic set_dma(input logic r, input logic w, input int a, input logic [DW-1:0] d);
        dma_req = r; dma_we = w; dma_addr = AW'(a); dma_wdata = d;
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1;
        set_cpu(0, 0, 0, 0);
        set_dma(0, 0, 0, 0);
        @(negedge clk);
        chk("rst_mem_strobes", {mem_we, mem_re}, 2'b00);
        step();
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        preload = 1'b1;
        set_cpu(0, 0, 0, 0);
        set_dma(0, 0, 0, 0);
        @(negedge clk);
        #1 preload = 1'b0;
        @(negedge clk);
        chk("rst_rvalid", {cpu_rvalid, dma_rvalid}, 2'b00);
        chk("rst_mem_strobes", {mem_we, mem_re}, 2'b00);

        // CPU read alone: same-cycle grant, data next cycle
        step();
        rst = 1'b0;
        set_cpu(1, 0, 5, 0);
        @(negedge clk);
        chk("cpu_rd_gnt", {cpu_gnt, cpu_stall, mem_re, mem_we}, 4'b1010);
        chk("cpu_rd_addr", mem_addr, 5);
        step();
        set_cpu(0, 0, 0, 0);
        @(negedge clk);
        chk("cpu_rd_rvalid", {cpu_rvalid, dma_rvalid}, 2'b10);
        chk("cpu_rd_data", cpu_rdata, 32'hDEADBEEF);

        // CPU write vs DMA read of the same word
        do_reset();
        step();
        set_cpu(1, 1, 3, 32'h11);
        set_dma(1, 0, 3, 0);
        @(negedge clk);
        chk("both_c1_gnt", {cpu_gnt, dma_gnt, mem_we, mem_re}, 4'b1010);
        chk("both_c1_wdata", mem_wdata, 32'h11);
        step();
        set_cpu(0, 0, 0, 0);
        @(negedge clk);
        chk("both_c2_gnt", {cpu_gnt, dma_gnt, mem_re}, 3'b011);
        chk("both_c2_addr", mem_addr, 3);
        step();
        set_dma(0, 0, 0, 0);
        @(negedge clk);
        chk("both_rvalid", {cpu_rvalid, dma_rvalid}, 2'b01);
        chk("both_dma_rdata", dma_rdata, 32'h11);

        // Back-to-back reads from different ports
        step();
        set_cpu(1, 0, 1, 0);
        @(negedge clk);
        chk("b2b_cpu_gnt", cpu_gnt, 1);
        step();
        set_cpu(0, 0, 0, 0);
        set_dma(1, 0, 2, 0);
        @(negedge clk);
        chk("b2b_c2", {cpu_rvalid, dma_rvalid, dma_gnt}, 3'b101);
        chk("b2b_cpu_rdata", cpu_rdata, pat(1));
        step();
        set_dma(0, 0, 0, 0);
        @(negedge clk);
        chk("b2b_c3", {cpu_rvalid, dma_rvalid}, 2'b01);
        chk("b2b_dma_rdata", dma_rdata, pat(2));

        // Contested reads, then reset right after a CPU read grant
        do_reset();
        for (int k = 1; k <= 3; k++) begin
            step();
            set_cpu(1, 0, 7, 0);
            set_dma(1, 0, 20, 0);
            @(negedge clk);
            chk($sformatf("pre_gnt_%0d", k), {cpu_gnt, dma_gnt}, {~exp_dma_win(k), exp_dma_win(k)});
        end
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_rvalid", {cpu_rvalid, dma_rvalid}, 2'b00);

        // Contested run from a freshly reset counter
        for (int k = 1; k <= 10; k++) begin
            step();
            rst = 1'b0;
            @(negedge clk);
            chk($sformatf("cont_gnt_%0d", k), {cpu_gnt, dma_gnt, cpu_stall},
                {~exp_dma_win(k), exp_dma_win(k), exp_dma_win(k)});
        end
        step();
        set_cpu(0, 0, 0, 0);
        set_dma(0, 0, 0, 0);
        @(negedge clk);
        step();
        @(negedge clk);
        chk("cpu_q_drain", cpu_q.size(), 0);
        chk("dma_q_drain", dma_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfails);
        $finish;
    end

endmodule
